// File: rtl/vga_sync_decoder.sv
// VGA timing sink: rebuilds the pixel position from hsync/vsync/display_on,
// acquires lock, and flags sync or display-enable edges that arrive off-timing.
module vga_sync_decoder #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        display_on,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        locked,
  output logic        frame_start,
  output logic        err_h,
  output logic        err_v,
  output logic        err_de,
  output logic [15:0] err_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int TO_MAX  = 2 * H_TOTAL;
  localparam int TO_W    = $clog2(TO_MAX + 1);
  localparam int GOOD_W  = $clog2(LOCK_LINES + 1);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_ON    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_OFF   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_ON    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_OFF   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [TO_W-1:0]   TO_SAT    = TO_W'(TO_MAX);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_LINES);

  typedef enum logic [1:0] {SEARCH, H_ACQ, V_ACQ, LOCKED} state_t;

  state_t            state_reg, state_next;
  logic [GOOD_W-1:0] good_reg, good_next;
  logic [TO_W-1:0]   timeout_reg, timeout_next;
  logic              hs_prev_reg, vs_prev_reg;
  logic [9:0]        x_reg, y_reg, px, py, x_next, y_next;
  logic              frame_start_reg, err_h_reg, err_v_reg, err_de_reg;
  logic [15:0]       err_count_reg;
  logic              hs_rise, hs_fall, vs_rise, vs_fall;
  logic              bad_h, bad_v, bad_de, in_lock;

  assign pos_x       = x_reg;
  assign pos_y       = y_reg;
  assign locked      = (state_reg == LOCKED);
  assign frame_start = frame_start_reg;
  assign err_h       = err_h_reg;
  assign err_v       = err_v_reg;
  assign err_de      = err_de_reg;
  assign err_count   = err_count_reg;

  // Edge detection, position prediction/recovery and the off-timing checks.
  always_comb begin
    hs_rise = hsync & ~hs_prev_reg;
    hs_fall = ~hsync & hs_prev_reg;
    vs_rise = vsync & ~vs_prev_reg;
    vs_fall = ~vsync & vs_prev_reg;
    px      = (x_reg == X_LAST) ? 10'd0 : x_reg + 10'd1;
    py      = y_reg;
    if (px == 10'd0) py = (y_reg == Y_LAST) ? 10'd0 : y_reg + 10'd1;
    x_next  = hs_rise ? HS_ON : px;
    y_next  = vs_rise ? VS_ON : py;
    timeout_next = timeout_reg;
    if (hs_rise)                  timeout_next = '0;
    else if (timeout_reg != TO_SAT) timeout_next = timeout_reg + TO_W'(1);
    in_lock = (state_reg == LOCKED);
    bad_h   = (hs_rise && px != HS_ON) || (hs_fall && px != HS_OFF);
    bad_v   = (vs_rise && (px != 10'd0 || py != VS_ON)) ||
              (vs_fall && (px != 10'd0 || py != VS_OFF));
    bad_de  = display_on != ((x_next < H_VIS) && (y_next < V_VIS));
  end

  // Lock state machine: next state and good-line counter, timeout wins over all.
  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    case (state_reg)
      SEARCH: begin
        if (hs_rise) begin
          state_next = H_ACQ;
          good_next  = '0;
        end
      end
      H_ACQ: begin
        if (hs_rise) begin
          if (px == HS_ON) begin
            good_next = good_reg + GOOD_W'(1);
            if (good_next == GOOD_LOCK) state_next = V_ACQ;
          end else begin
            good_next = '0;
          end
        end
      end
      V_ACQ: begin
        if (hs_rise && px != HS_ON) begin
          state_next = H_ACQ;
          good_next  = '0;
        end else if (vs_rise && px == 10'd0) begin
          state_next = LOCKED;
        end
      end
      default: begin
        if (bad_h) begin
          state_next = H_ACQ;
          good_next  = '0;
        end else if (bad_v) begin
          state_next = V_ACQ;
        end
      end
    endcase
    if (timeout_next == TO_SAT) begin
      state_next = SEARCH;
      good_next  = '0;
    end
  end

  // State, history, recovered position and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= SEARCH;
      good_reg        <= '0;
      timeout_reg     <= '0;
      hs_prev_reg     <= 1'b0;
      vs_prev_reg     <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      frame_start_reg <= 1'b0;
      err_h_reg       <= 1'b0;
      err_v_reg       <= 1'b0;
      err_de_reg      <= 1'b0;
      err_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      good_reg        <= good_next;
      timeout_reg     <= timeout_next;
      hs_prev_reg     <= hsync;
      vs_prev_reg     <= vsync;
      x_reg           <= x_next;
      y_reg           <= y_next;
      frame_start_reg <= in_lock && x_next == 10'd0 && y_next == 10'd0;
      err_h_reg       <= in_lock && bad_h;
      err_v_reg       <= in_lock && bad_v;
      err_de_reg      <= in_lock && bad_de;
      if (in_lock && (bad_h || bad_v || bad_de) && err_count_reg != 16'hFFFF)
        err_count_reg <= err_count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster: a behavioural sync
// source with injectable faults, and per-cycle expectations derived from
// raster positions (lock point, error sample, timeout distance).
module tb_vga_sync_decoder;
  localparam int HV = 16, HF = 4, HSY = 6, HB = 6;
  localparam int VV = 12, VF = 3, VSY = 2, VB = 4;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int HSON = HV + HF, HSOFF = HV + HF + HSY;
  localparam int VSON = VV + VF, VSOFF = VV + VF + VSY;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0, reset, hsync, vsync, display_on;
  logic [9:0] pos_x, pos_y;
  logic locked, frame_start, err_h, err_v, err_de;
  logic [15:0] err_count;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB), .LOCK_LINES(4)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .pos_x(pos_x), .pos_y(pos_y), .locked(locked), .frame_start(frame_start),
    .err_h(err_h), .err_v(err_v), .err_de(err_de), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int gx = 0, gy = 0, cx = 0, cy = 0;
  int hs_delay_line = -1, hs_kill_lo = -1, hs_kill_hi = -1, de_gx = -1, de_gy = -1;
  bit vs_early = 0;
  int errors = 0, checks = 0, exp_err_count = 0, rises_since_reset = 0;

  // Drive one raster sample, clock it in, and advance the source position.
  task automatic step();
    hsync = (gy == hs_delay_line) ? (gx >= HSON + 1 && gx < HSOFF) : (gx >= HSON && gx < HSOFF);
    if (gy >= hs_kill_lo && gy < hs_kill_hi) hsync = 1'b0;
    vsync = vs_early ? (gy >= VSON - 1 && gy < VSOFF) : (gy >= VSON && gy < VSOFF);
    display_on = (gx < HV) && (gy < VV) && !(gx == de_gx && gy == de_gy);
    @(posedge clk); #1;
    cx = gx; cy = gy;
    if (hsync && gx == HSON) rises_since_reset++;
    gx++;
    if (gx == HT) begin gx = 0; gy = (gy == VT - 1) ? 0 : gy + 1; end
  endtask

  task automatic align();
    while (gx != 0 || gy != 0) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; hsync = 1'b0; vsync = 1'b0; display_on = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (locked !== 1'b0) begin $display("FAIL reset_locked got %b want 0", locked); errors++; end
    checks++;
    if (pos_x !== 10'd0 || pos_y !== 10'd0) begin
      $display("FAIL reset_pos got (%0d,%0d) want (0,0)", pos_x, pos_y); errors++; end
    checks++;
    if ({frame_start, err_h, err_v, err_de} !== 4'b0000) begin
      $display("FAIL reset_pulses got %b want 0000", {frame_start, err_h, err_v, err_de}); errors++; end
    checks++;
    if (err_count !== 16'd0) begin $display("FAIL reset_err_count got %0d want 0", err_count); errors++; end
    reset = 1'b0; rises_since_reset = 0; gx = 0; gy = 0;
    $display("test_reset done");
  endtask

  // From reset: lock at the first vsync rise after five hsync periods, then track exactly.
  task automatic test_lock(input int frames, input string name);
    logic el = 1'b0; bit bad = 0;
    for (int i = 0; i < frames * FRAME && !bad; i++) begin
      step();
      if (cx == 0 && cy == VSON && rises_since_reset >= 5) el = 1'b1;
      checks++;
      if (locked !== el) begin
        $display("FAIL %s_locked at (%0d,%0d) got %b want %b", name, cx, cy, locked, el); errors++; bad = 1; end
      checks++;
      if ({err_h, err_v, err_de} !== 3'b000 || err_count !== 16'(exp_err_count)) begin
        $display("FAIL %s_err at (%0d,%0d) got %b/%0d want 000/%0d", name, cx, cy,
                 {err_h, err_v, err_de}, err_count, exp_err_count); errors++; bad = 1; end
      if (el) begin
        checks++;
        if (pos_x !== 10'(cx) || pos_y !== 10'(cy) || frame_start !== (cx == 0 && cy == 0)) begin
          $display("FAIL %s_pos got (%0d,%0d) fs=%b want (%0d,%0d)", name, pos_x, pos_y, frame_start, cx, cy);
          errors++; bad = 1; end
      end
    end
    $display("%s done: frames=%0d", name, frames);
  endtask

  task automatic test_frame_start();
    int last = -1, n = 0;
    align();
    for (int i = 0; i <= 2 * FRAME; i++) begin
      step();
      if (frame_start) begin
        checks++;
        if (pos_x !== 10'd0 || pos_y !== 10'd0) begin
          $display("FAIL fs_pos got (%0d,%0d) want (0,0)", pos_x, pos_y); errors++; end
        if (last >= 0) begin
          checks++;
          if (i - last != FRAME) begin $display("FAIL fs_period got %0d want %0d", i - last, FRAME); errors++; end
        end
        last = i; n++;
      end
    end
    checks++;
    if (n != 3) begin $display("FAIL fs_count got %0d want 3", n); errors++; end
    $display("test_frame_start done: pulses=%0d", n);
  endtask

  // One late hsync rise: single err_h, lock lost until the next vsync rise.
  task automatic test_hsync_delay();
    int line, eidx, idx; logic el; logic [2:0] ee; bit bad = 0;
    align();
    line = int'($urandom_range(8, 1)); hs_delay_line = line; eidx = line * HT + HSON + 1;
    for (int i = 0; i < FRAME; i++) begin
      step(); idx = cy * HT + cx;
      el = (idx < eidx) || (idx >= VSON * HT);
      ee = (idx == eidx) ? 3'b100 : 3'b000;
      if (ee != 3'b000) exp_err_count++;
      if (!bad) begin
        checks++;
        if (locked !== el || {err_h, err_v, err_de} !== ee || err_count !== 16'(exp_err_count)) begin
          $display("FAIL hdelay at (%0d,%0d) got lk=%b err=%b cnt=%0d want lk=%b err=%b cnt=%0d", cx, cy,
                   locked, {err_h, err_v, err_de}, err_count, el, ee, exp_err_count); errors++; bad = 1; end
        if (el && !bad) begin
          checks++;
          if (pos_x !== 10'(cx) || pos_y !== 10'(cy)) begin
            $display("FAIL hdelay_pos got (%0d,%0d) want (%0d,%0d)", pos_x, pos_y, cx, cy); errors++; bad = 1; end
        end
      end
    end
    hs_delay_line = -1;
    $display("test_hsync_delay done: line=%0d err_count=%0d", line, err_count);
  endtask

  // Single-cycle display_on dropout inside the visible area keeps lock.
  task automatic test_de_glitch();
    logic [2:0] ee; bit bad = 0;
    for (int f = 0; f < 2; f++) begin
      align();
      de_gx = int'($urandom_range(HV - 1, 0)); de_gy = int'($urandom_range(VV - 1, 0));
      for (int i = 0; i < FRAME; i++) begin
        step();
        ee = (cx == de_gx && cy == de_gy) ? 3'b001 : 3'b000;
        if (ee != 3'b000) exp_err_count++;
        if (!bad) begin
          checks++;
          if (locked !== 1'b1 || {err_h, err_v, err_de} !== ee || err_count !== 16'(exp_err_count)) begin
            $display("FAIL deglitch at (%0d,%0d) got lk=%b err=%b cnt=%0d want lk=1 err=%b cnt=%0d", cx, cy,
                     locked, {err_h, err_v, err_de}, err_count, ee, exp_err_count); errors++; bad = 1; end
        end
      end
      $display("test_de_glitch frame %0d: glitch at (%0d,%0d) err_count=%0d", f, de_gx, de_gy, err_count);
      de_gx = -1; de_gy = -1;
    end
  endtask

  // hsync held low: lock drops 2*H_TOTAL cycles after the last rise, no error pulses.
  task automatic test_timeout();
    int line, last_rise, idx; logic el; bit bad = 0;
    align();
    line = int'($urandom_range(7, 1)); hs_kill_lo = line; hs_kill_hi = line + 3;
    last_rise = (line - 1) * HT + HSON;
    for (int i = 0; i < FRAME; i++) begin
      step(); idx = cy * HT + cx;
      el = (idx - last_rise < 2 * HT) || (idx >= VSON * HT);
      if (!bad) begin
        checks++;
        if (locked !== el || {err_h, err_v, err_de} !== 3'b000 || err_count !== 16'(exp_err_count)) begin
          $display("FAIL timeout at (%0d,%0d) got lk=%b err=%b cnt=%0d want lk=%b err=000 cnt=%0d", cx, cy,
                   locked, {err_h, err_v, err_de}, err_count, el, exp_err_count); errors++; bad = 1; end
      end
    end
    hs_kill_lo = -1; hs_kill_hi = -1;
    $display("test_timeout done: hsync low from line %0d", line);
  endtask

  // vsync rising one line early: err_v, then relock on the next correct frame.
  task automatic test_vsync_early();
    int idx, eidx; logic el; logic [2:0] ee; bit bad = 0;
    align();
    eidx = (VSON - 1) * HT;
    for (int f = 0; f < 2; f++) begin
      vs_early = (f == 0);
      for (int i = 0; i < FRAME; i++) begin
        step(); idx = cy * HT + cx;
        el = (f == 0) ? (idx < eidx) : (idx >= VSON * HT);
        ee = (f == 0 && idx == eidx) ? 3'b010 : 3'b000;
        if (ee != 3'b000) exp_err_count++;
        if (!bad) begin
          checks++;
          if (locked !== el || {err_h, err_v, err_de} !== ee || err_count !== 16'(exp_err_count)) begin
            $display("FAIL vearly f%0d at (%0d,%0d) got lk=%b err=%b cnt=%0d want lk=%b err=%b cnt=%0d", f, cx, cy,
                     locked, {err_h, err_v, err_de}, err_count, el, ee, exp_err_count); errors++; bad = 1; end
        end
      end
    end
    vs_early = 0;
    $display("test_vsync_early done: err_count=%0d", err_count);
  endtask

  task automatic test_reset_midframe();
    int n = int'($urandom_range(FRAME - 1, 0));
    repeat (n) step();
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (locked !== 1'b0 || pos_x !== 10'd0 || pos_y !== 10'd0 || err_count !== 16'd0) begin
      $display("FAIL midreset got lk=%b pos=(%0d,%0d) cnt=%0d want 0 (0,0) 0", locked, pos_x, pos_y, err_count);
      errors++; end
    exp_err_count = 0; rises_since_reset = 0;
    $display("test_reset_midframe: reset at (%0d,%0d)", cx, cy);
    test_lock(2, "relock");
  endtask

  initial begin
    test_reset();
    test_lock(3, "lock");
    test_frame_start();
    test_hsync_delay();
    test_de_glitch();
    test_timeout();
    test_vsync_early();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
